// File: rtl/pcie_pio_pkg.sv
// Shared types and helpers for the PCIe PIO memory path (bridge and TX engine).
package pcie_pio_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StRdReq,
    StRdWait,
    StRdOut
  } pio_bridge_state_t;

  localparam logic [31:0] PIO_ERR_DATA = 32'hFFFF_FFFF;

  // Bus lane carrying the addressed DW; only a 64-bit bus has two lanes.
  function automatic logic pio_lane_sel(input logic [2:0] addr_lo, input int unsigned data_width);
    return (data_width == 64) ? addr_lo[2] : 1'b0;
  endfunction

  // Byte enables of one DW within a request: first DW uses fbe (also for len 1), last lbe.
  function automatic logic [3:0] pio_dw_be(input logic first, input logic last,
                                           input logic [3:0] fbe, input logic [3:0] lbe);
    if (first) return fbe;
    if (last) return lbe;
    return 4'hF;
  endfunction

  // Zero the bytes of a DW whose enable is clear.
  function automatic logic [31:0] pio_be_mask(input logic [31:0] dw, input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? dw[8*b +: 8] : 8'h00;
    return m;
  endfunction

endpackage

// File: rtl/pcie_pio_mem_bridge_if.sv
// Handshaked memory bus between the PIO bridge (master) and a memory/register target (slave).
interface pcie_pio_mem_bridge_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 13
);
  logic                    valid;
  logic                    ready;
  logic                    wren;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output valid, wren, addr, wstrb, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, wren, addr, wstrb, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/pcie_pio_mem_bridge.sv
// Sequences PIO single-DW writes and multi-DW reads onto a handshaked memory bus, one beat per
// DW, streaming read DWs to the TX completion builder. Timeouts turn the rest of a read into
// all-ones DWs flagged as errors.
module pcie_pio_mem_bridge
  import pcie_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 13,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_wr_valid,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [3:0]            i_wr_be,
  input  logic [31:0]           i_wr_data,
  output logic                  o_wr_busy,
  input  logic                  i_rd_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_rd_req_addr,
  input  logic [9:0]            i_rd_req_len,
  input  logic [3:0]            i_rd_req_fbe,
  input  logic [3:0]            i_rd_req_lbe,
  output logic                  o_rd_req_ready,
  output logic                  o_rd_data_valid,
  output logic [31:0]           o_rd_data,
  output logic                  o_rd_data_last,
  output logic                  o_rd_data_err,
  input  logic                  i_rd_data_ready,
  pcie_pio_mem_bridge_if.master mem,
  output logic                  o_err_pulse
);

  localparam int unsigned Lanes = DATA_WIDTH / 32;
  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  function automatic logic [ADDR_WIDTH-1:0] bus_align(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    r = a;
    r[1:0] = 2'b00;
    if (DATA_WIDTH == 64) r[2] = 1'b0;
    return r;
  endfunction

  function automatic logic [StrbW-1:0] lane_strb(input logic [3:0] be, input logic lane);
    logic [StrbW-1:0] s;
    s = '0;
    for (int l = 0; l < int'(Lanes); l++) if (l == int'(lane)) s[4*l +: 4] = be;
    return s;
  endfunction

  function automatic logic [31:0] lane_dw(input logic [DATA_WIDTH-1:0] d, input logic lane);
    logic [31:0] w;
    w = '0;
    for (int l = 0; l < int'(Lanes); l++) if (l == int'(lane)) w = d[32*l +: 32];
    return w;
  endfunction

  pio_bridge_state_t     state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [10:0]           cnt_q, cnt_d;  // DWs left including the current one
  logic                  first_q, first_d;
  logic [3:0]            fbe_q, fbe_d, lbe_q, lbe_d;
  logic                  err_mode_q, err_mode_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic                  mem_valid_q, mem_valid_d, mem_wren_q, mem_wren_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [StrbW-1:0]      mem_wstrb_q, mem_wstrb_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, rd_err_q, rd_err_d;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  err_pulse_q, err_pulse_d, wr_busy_q, wr_busy_d;

  logic                  tmo_hit;
  logic                  cur_last;
  logic [ADDR_WIDTH-1:0] addr_inc;

  assign o_rd_req_ready = i_nrst && (state_q == StIdle) && !i_wr_valid && i_rd_req_valid;
  assign tmo_hit        = (tmo_q == TmoLast);
  assign cur_last       = (cnt_q == 11'd1);
  assign addr_inc       = addr_q + ADDR_WIDTH'(4);

  // Next-state and next-output logic for the request sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    fbe_d       = fbe_q;
    lbe_d       = lbe_q;
    err_mode_d  = err_mode_q;
    tmo_d       = tmo_q;
    mem_valid_d = mem_valid_q;
    mem_wren_d  = mem_wren_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    rd_last_d   = rd_last_q;
    rd_err_d    = rd_err_q;
    err_pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        tmo_d      = '0;
        err_mode_d = 1'b0;
        if (i_wr_valid) begin
          state_d     = StWrReq;
          addr_d      = i_wr_addr;
          mem_valid_d = 1'b1;
          mem_wren_d  = 1'b1;
          mem_addr_d  = bus_align(i_wr_addr);
          mem_wstrb_d = lane_strb(i_wr_be, pio_lane_sel(i_wr_addr[2:0], DATA_WIDTH));
          mem_wdata_d = {Lanes{i_wr_data}};
        end else if (o_rd_req_ready) begin
          state_d     = StRdReq;
          addr_d      = i_rd_req_addr;
          cnt_d       = (i_rd_req_len == 10'd0) ? 11'd1024 : {1'b0, i_rd_req_len};
          first_d     = 1'b1;
          fbe_d       = i_rd_req_fbe;
          lbe_d       = i_rd_req_lbe;
          mem_valid_d = 1'b1;
          mem_wren_d  = 1'b0;
          mem_addr_d  = bus_align(i_rd_req_addr);
          mem_wstrb_d = '0;
        end
      end
      StWrReq: begin
        if (mem.ready) begin
          mem_valid_d = 1'b0;
          mem_wren_d  = 1'b0;
          state_d     = StIdle;
        end else if (tmo_hit) begin
          // Write is dropped silently apart from the error pulse.
          mem_valid_d = 1'b0;
          mem_wren_d  = 1'b0;
          err_pulse_d = 1'b1;
          state_d     = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRdReq, StRdWait: begin
        if ((state_q == StRdReq) && mem.ready) begin
          mem_valid_d = 1'b0;
          tmo_d       = '0;
          state_d     = StRdWait;
        end else if ((state_q == StRdWait) && mem.rvalid) begin
          rd_valid_d = 1'b1;
          rd_data_d  = pio_be_mask(lane_dw(mem.rdata, pio_lane_sel(addr_q[2:0], DATA_WIDTH)),
                                   pio_dw_be(first_q, cur_last, fbe_q, lbe_q));
          rd_last_d  = cur_last;
          rd_err_d   = 1'b0;
          state_d    = StRdOut;
        end else if (tmo_hit) begin
          // Abort: this and every remaining DW goes out as error data, no more bus beats.
          mem_valid_d = 1'b0;
          err_pulse_d = 1'b1;
          err_mode_d  = 1'b1;
          rd_valid_d  = 1'b1;
          rd_data_d   = PIO_ERR_DATA;
          rd_last_d   = cur_last;
          rd_err_d    = 1'b1;
          state_d     = StRdOut;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRdOut: begin
        if (i_rd_data_ready) begin
          rd_valid_d = 1'b0;
          if (cur_last) begin
            err_mode_d = 1'b0;
            state_d    = StIdle;
          end else begin
            cnt_d   = cnt_q - 11'd1;
            addr_d  = addr_inc;
            first_d = 1'b0;
            if (err_mode_q) begin
              rd_valid_d = 1'b1;
              rd_data_d  = PIO_ERR_DATA;
              rd_last_d  = (cnt_q == 11'd2);
              rd_err_d   = 1'b1;
            end else begin
              mem_valid_d = 1'b1;
              mem_wren_d  = 1'b0;
              mem_addr_d  = bus_align(addr_inc);
              mem_wstrb_d = '0;
              tmo_d       = '0;
              state_d     = StRdReq;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    wr_busy_d = (state_d != StIdle);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      fbe_q       <= '0;
      lbe_q       <= '0;
      err_mode_q  <= 1'b0;
      tmo_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      rd_err_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      wr_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      fbe_q       <= fbe_d;
      lbe_q       <= lbe_d;
      err_mode_q  <= err_mode_d;
      tmo_q       <= tmo_d;
      mem_valid_q <= mem_valid_d;
      mem_wren_q  <= mem_wren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
      rd_err_q    <= rd_err_d;
      err_pulse_q <= err_pulse_d;
      wr_busy_q   <= wr_busy_d;
    end
  end

  assign mem.valid       = mem_valid_q;
  assign mem.wren        = mem_wren_q;
  assign mem.addr        = mem_addr_q;
  assign mem.wstrb       = mem_wstrb_q;
  assign mem.wdata       = mem_wdata_q;
  assign o_rd_data_valid = rd_valid_q;
  assign o_rd_data       = rd_data_q;
  assign o_rd_data_last  = rd_last_q;
  assign o_rd_data_err   = rd_err_q;
  assign o_err_pulse     = err_pulse_q;
  assign o_wr_busy       = wr_busy_q;

endmodule

// File: tb/tb_pcie_pio_mem_bridge.sv
// Directed bench for pcie_pio_mem_bridge on a 64-bit bus, 13-bit addresses, timeout 8 cycles.
module tb_pcie_pio_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic        wr_valid;
  logic [12:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        wr_busy;
  logic        rd_req_valid;
  logic [12:0] rd_req_addr;
  logic [9:0]  rd_req_len;
  logic [3:0]  rd_req_fbe;
  logic [3:0]  rd_req_lbe;
  logic        rd_req_ready;
  logic        rd_data_valid;
  logic [31:0] rd_data;
  logic        rd_data_last;
  logic        rd_data_err;
  logic        rd_data_ready;
  logic        err_pulse;

  pcie_pio_mem_bridge_if #(.DATA_WIDTH(64), .ADDR_WIDTH(13)) mem_bus ();

  pcie_pio_mem_bridge #(
    .DATA_WIDTH    (64),
    .ADDR_WIDTH    (13),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk          (clk),
    .i_nrst         (nrst),
    .i_wr_valid     (wr_valid),
    .i_wr_addr      (wr_addr),
    .i_wr_be        (wr_be),
    .i_wr_data      (wr_data),
    .o_wr_busy      (wr_busy),
    .i_rd_req_valid (rd_req_valid),
    .i_rd_req_addr  (rd_req_addr),
    .i_rd_req_len   (rd_req_len),
    .i_rd_req_fbe   (rd_req_fbe),
    .i_rd_req_lbe   (rd_req_lbe),
    .o_rd_req_ready (rd_req_ready),
    .o_rd_data_valid(rd_data_valid),
    .o_rd_data      (rd_data),
    .o_rd_data_last (rd_data_last),
    .o_rd_data_err  (rd_data_err),
    .i_rd_data_ready(rd_data_ready),
    .mem            (mem_bus),
    .o_err_pulse    (err_pulse)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side knobs and logs. Handshakes are logged at the negedge before the edge that takes them.
  logic        ready_en, rvalid_en, tx_toggle;
  logic [12:0] hs_addr_q[$];
  logic        hs_wren_q[$];
  logic [7:0]  hs_strb_q[$];
  logic [63:0] hs_data_q[$];
  logic [12:0] rd_addr_q[$];
  logic [33:0] rx_q[$];  // {err, last, data}
  int          err_cnt = 0;
  int          valid_cycles = 0;

  // Memory content: DW at byte address a.
  function automatic logic [31:0] pat(input logic [12:0] a);
    return 32'h8877_6655 ^ {19'b0, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory target: one-cycle ready, read data one cycle after each accepted read.
  initial begin
    logic [12:0] a;
    mem_bus.ready  = 1'b0;
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata  = '0;
    forever begin
      @(negedge clk);
      mem_bus.rvalid = 1'b0;
      if (rvalid_en && rd_addr_q.size() > 0) begin
        a = rd_addr_q.pop_front();
        mem_bus.rdata  = {pat(a + 13'd4), pat(a)};
        mem_bus.rvalid = 1'b1;
      end
      mem_bus.ready = ready_en && mem_bus.valid;
      if (mem_bus.ready) begin
        hs_addr_q.push_back(mem_bus.addr);
        hs_wren_q.push_back(mem_bus.wren);
        hs_strb_q.push_back(mem_bus.wstrb);
        hs_data_q.push_back(mem_bus.wdata);
        if (!mem_bus.wren) rd_addr_q.push_back(mem_bus.addr);
      end
      if (err_pulse) err_cnt++;
    end
  end

  // TX engine: always ready, or toggling every cycle.
  initial begin
    rd_data_ready = 1'b0;
    forever begin
      @(negedge clk);
      rd_data_ready = tx_toggle ? ~rd_data_ready : 1'b1;
      if (rd_data_valid) valid_cycles++;
      if (rd_data_valid && rd_data_ready) rx_q.push_back({rd_data_err, rd_data_last, rd_data});
    end
  end

  task automatic clear_logs();
    hs_addr_q.delete();
    hs_wren_q.delete();
    hs_strb_q.delete();
    hs_data_q.delete();
    rx_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (!wr_busy && !rd_data_valid && !mem_bus.valid) ok = 1'b1;
    end
    if (!ok) check({tag, "_idle_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      if (rx_q.size() >= n) ok = 1'b1;
    end
    if (!ok) check({tag, "_rx_timeout"}, 64'(rx_q.size()), 64'(n));
  endtask

  task automatic do_write(input logic [12:0] a, input logic [3:0] be, input logic [31:0] d);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_be    = be;
    wr_data  = d;
    #1 check("wr_valid_before_accept", 64'(mem_bus.valid), 64'd0);
    @(negedge clk);
    wr_valid = 1'b0;
    #1 check("wr_valid_after_accept", 64'(mem_bus.valid), 64'd1);
    check("wr_busy", 64'(wr_busy), 64'd1);
  endtask

  task automatic rd_request(input logic [12:0] a, input logic [9:0] len,
                            input logic [3:0] fbe, input logic [3:0] lbe);
    bit ok = 1'b0;
    @(negedge clk);
    rd_req_valid = 1'b1;
    rd_req_addr  = a;
    rd_req_len   = len;
    rd_req_fbe   = fbe;
    rd_req_lbe   = lbe;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (rd_req_ready) ok = 1'b1;
      @(negedge clk);
    end
    rd_req_valid = 1'b0;
    if (!ok) check("rd_req_accept_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int bad, nlast, lastpos, e0, v0, r0;
    bit seen, early;
    nrst = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    rd_req_valid = 1'b1; rd_req_addr = '0; rd_req_len = 10'd1; rd_req_fbe = 4'hF;
    rd_req_lbe = 4'hF;
    ready_en = 1'b1; rvalid_en = 1'b1; tx_toggle = 1'b0;

    // Reset: outputs low even with a read request pending.
    repeat (3) @(negedge clk);
    #1;
    check("rst_wr_busy", 64'(wr_busy), 64'd0);
    check("rst_mem_valid", 64'(mem_bus.valid), 64'd0);
    check("rst_rd_valid", 64'(rd_data_valid), 64'd0);
    check("rst_rd_req_ready", 64'(rd_req_ready), 64'd0);
    check("rst_err_pulse", 64'(err_pulse), 64'd0);
    rd_req_valid = 1'b0;
    nrst = 1'b1;

    // Writes: lane 0 and lane 1 on the 64-bit bus.
    clear_logs();
    do_write(13'h0040, 4'hC, 32'hA5A5_1234);
    wait_idle("wr0");
    do_write(13'h0044, 4'h3, 32'h0BAD_F00D);
    wait_idle("wr1");
    check("wr_hs_count", 64'(hs_addr_q.size()), 64'd2);
    check("wr0_addr", 64'(hs_addr_q[0]), 64'h0040);
    check("wr0_wren", 64'(hs_wren_q[0]), 64'd1);
    check("wr0_wstrb", 64'(hs_strb_q[0]), 64'h0C);
    check("wr0_wdata", hs_data_q[0], 64'hA5A5_1234_A5A5_1234);
    check("wr1_addr", 64'(hs_addr_q[1]), 64'h0040);
    check("wr1_wstrb", 64'(hs_strb_q[1]), 64'h30);

    // Read 3 DWs at 0x0FFC: 64-bit aligned beats 0x0FF8 (hi), 0x1000 (lo), 0x1000 (hi).
    clear_logs();
    rd_request(13'h0FFC, 10'd3, 4'hE, 4'h3);
    wait_rx(3, 200, "rd3");
    wait_idle("rd3");
    check("rd3_hs_count", 64'(hs_addr_q.size()), 64'd3);
    check("rd3_addr0", 64'(hs_addr_q[0]), 64'h0FF8);
    check("rd3_addr1", 64'(hs_addr_q[1]), 64'h1000);
    check("rd3_addr2", 64'(hs_addr_q[2]), 64'h1000);
    check("rd3_wren", 64'(hs_wren_q[0]), 64'd0);
    check("rd3_count", 64'(rx_q.size()), 64'd3);
    check("rd3_dw0", 64'(rx_q[0]), {30'd0, 2'b00, 32'h8877_6900});
    check("rd3_dw1", 64'(rx_q[1]), {30'd0, 2'b00, 32'h8877_7655});
    check("rd3_dw2", 64'(rx_q[2]), {30'd0, 2'b01, 32'h0000_7651});

    // Address wrap at the top of the 13-bit space.
    clear_logs();
    rd_request(13'h1FFC, 10'd2, 4'hF, 4'hF);
    wait_rx(2, 200, "wrap");
    wait_idle("wrap");
    check("wrap_addr0", 64'(hs_addr_q[0]), 64'h1FF8);
    check("wrap_addr1", 64'(hs_addr_q[1]), 64'h0000);
    check("wrap_dw0", 64'(rx_q[0]), {30'd0, 2'b00, 32'h8877_79A9});
    check("wrap_dw1", 64'(rx_q[1]), {30'd0, 2'b01, 32'h8877_6655});

    // Write and read request together: write first, read ready the cycle after the write beat.
    clear_logs();
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 13'h0100; wr_be = 4'hF; wr_data = 32'hDEAD_BEEF;
    rd_req_valid = 1'b1; rd_req_addr = 13'h0200; rd_req_len = 10'd1;
    rd_req_fbe = 4'h5; rd_req_lbe = 4'h0;
    #1 check("both_rd_ready_low", 64'(rd_req_ready), 64'd0);
    @(negedge clk);
    wr_valid = 1'b0;
    seen = 1'b0; early = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (seen) begin
        check("both_rd_ready_after_wr", 64'(rd_req_ready), 64'd1);
        break;
      end
      if (rd_req_ready) early = 1'b1;
      if (hs_addr_q.size() > 0) seen = 1'b1;
      @(negedge clk);
    end
    check("both_rd_ready_early", 64'(early), 64'd0);
    @(negedge clk);
    rd_req_valid = 1'b0;
    wait_rx(1, 200, "both");
    wait_idle("both");
    check("both_hs_count", 64'(hs_addr_q.size()), 64'd2);
    check("both_first_wren", 64'(hs_wren_q[0]), 64'd1);
    check("both_first_addr", 64'(hs_addr_q[0]), 64'h0100);
    check("both_second_addr", 64'(hs_addr_q[1]), 64'h0200);
    check("both_rd_dw", 64'(rx_q[0]), {30'd0, 2'b01, 32'h0077_0055});

    // Length 0 means 1024 DWs; TX ready toggles every cycle.
    clear_logs();
    tx_toggle = 1'b1;
    rd_request(13'h0000, 10'd0, 4'hF, 4'hF);
    wait_rx(1024, 20000, "burst");
    wait_idle("burst");
    repeat (5) @(negedge clk);
    tx_toggle = 1'b0;
    bad = 0; nlast = 0; lastpos = -1;
    foreach (rx_q[k]) begin
      if (rx_q[k][32]) begin nlast++; lastpos = k; end
      if (rx_q[k][33] || rx_q[k][31:0] !== pat(13'(k * 4))) bad++;
    end
    check("burst_count", 64'(rx_q.size()), 64'd1024);
    check("burst_hs_count", 64'(hs_addr_q.size()), 64'd1024);
    check("burst_bad_data", 64'(bad), 64'd0);
    check("burst_last_count", 64'(nlast), 64'd1);
    check("burst_last_pos", 64'(lastpos), 64'd1023);

    // Read timeout: bus never ready.
    clear_logs();
    ready_en = 1'b0;
    e0 = err_cnt;
    rd_request(13'h0300, 10'd4, 4'hF, 4'hF);
    wait_rx(4, 300, "tmo_rd");
    wait_idle("tmo_rd");
    check("tmo_rd_err_pulses", 64'(err_cnt - e0), 64'd1);
    check("tmo_rd_hs_count", 64'(hs_addr_q.size()), 64'd0);
    check("tmo_rd_count", 64'(rx_q.size()), 64'd4);
    check("tmo_rd_dw0", 64'(rx_q[0]), {30'd0, 2'b10, 32'hFFFF_FFFF});
    check("tmo_rd_dw2", 64'(rx_q[2]), {30'd0, 2'b10, 32'hFFFF_FFFF});
    check("tmo_rd_dw3", 64'(rx_q[3]), {30'd0, 2'b11, 32'hFFFF_FFFF});

    // Write timeout: dropped with one error pulse.
    clear_logs();
    e0 = err_cnt;
    do_write(13'h0500, 4'hF, 32'h1234_5678);
    wait_idle("tmo_wr");
    check("tmo_wr_err_pulses", 64'(err_cnt - e0), 64'd1);
    check("tmo_wr_hs_count", 64'(hs_addr_q.size()), 64'd0);
    ready_en = 1'b1;

    // Reset while waiting for read data, then the data arrives late.
    clear_logs();
    rvalid_en = 1'b0;
    e0 = err_cnt;
    rd_request(13'h0400, 10'd4, 4'hF, 4'hF);
    for (int i = 0; i < 50 && hs_addr_q.size() == 0; i++) @(negedge clk);
    check("rst_mid_hs_seen", 64'(hs_addr_q.size()), 64'd1);
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    rvalid_en = 1'b1;
    v0 = valid_cycles;
    r0 = rx_q.size();
    repeat (20) @(negedge clk);
    #1;
    check("rst_mid_no_valid", 64'(valid_cycles - v0), 64'd0);
    check("rst_mid_no_rx", 64'(rx_q.size() - r0), 64'd0);
    check("rst_mid_idle", 64'(wr_busy), 64'd0);
    check("rst_mid_mem_valid", 64'(mem_bus.valid), 64'd0);
    check("rst_mid_no_err", 64'(err_cnt - e0), 64'd0);

    // Recovery: single DW from the upper lane.
    clear_logs();
    rd_request(13'h000C, 10'd1, 4'hF, 4'h0);
    wait_rx(1, 200, "recover");
    wait_idle("recover");
    check("recover_addr", 64'(hs_addr_q[0]), 64'h0008);
    check("recover_dw", 64'(rx_q[0]), {30'd0, 2'b01, 32'h8877_6659});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
